// File: rtl/pipe_wb_arb_pkg.sv
// Shared encodings and default widths for the write-back stage and its queue.
package pipe_wb_arb_pkg;

    localparam int unsigned DW_DEF     = 32;
    localparam int unsigned AW_DEF     = 5;
    localparam int unsigned QDEPTH_DEF = 4;

    // Load-type field from the MEM stage; unlisted codes behave as a word load.
    typedef enum logic [2:0] {
        LD_WORD = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4
    } ld_type_e;

    // Write-data source select; unlisted codes write zero.
    typedef enum logic [2:0] {
        SEL_PC4  = 3'd1,
        SEL_DMEM = 3'd4,
        SEL_ALU  = 3'd5
    } wb_sel_e;

endpackage

// File: rtl/wb_pend_queue.sv
// Pending-write FIFO for long-latency results: per-entry valid bits,
// WAW kill by address, and an associative lookup for the ID stage.
module wb_pend_queue
    import pipe_wb_arb_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned QDEPTH = QDEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          kill_en,
    input  logic [AW-1:0] kill_addr,
    input  logic [AW-1:0] lk_addr,
    output logic          lk_hit,
    output logic          full,
    output logic          empty,
    output logic          head_valid,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data
);

    localparam int unsigned IW = $clog2(QDEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic [AW-1:0]     addr_q [QDEPTH];
    logic [DW-1:0]     data_q [QDEPTH];
    logic [QDEPTH-1:0] vld_q;
    logic              do_push;
    logic              do_pop;

    assign wr_idx  = wr_ptr[IW-1:0];
    assign rd_idx  = rd_ptr[IW-1:0];
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_idx == rd_idx);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_valid = vld_q[rd_idx];
    assign head_addr  = addr_q[rd_idx];
    assign head_data  = data_q[rd_idx];

    // Entry payload storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wr_idx] <= push_addr;
            data_q[wr_idx] <= push_data;
        end
    end

    // Pointers and valid bits. Kill is applied first so a same-edge push to the
    // killed address (younger) still lands valid; pop clears its slot so valid
    // bits outside the occupied window are always zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                if (kill_en && (addr_q[i] == kill_addr)) begin
                    vld_q[i] <= 1'b0;
                end
            end
            if (do_pop) begin
                vld_q[rd_idx] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                vld_q[wr_idx] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
        end
    end

    // Hazard lookup over live entries; register $0 never reports a hit.
    always_comb begin
        lk_hit = 1'b0;
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == lk_addr)) begin
                lk_hit = 1'b1;
            end
        end
        if (lk_addr == '0) begin
            lk_hit = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_wb_arb.sv
// Registered write-back stage: selects and load-extends the MEM/WB result and
// shares the single regfile write port with queued long-latency results.
module pipe_wb_arb
    import pipe_wb_arb_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned QDEPTH = QDEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] dmem_out,
    input  logic [DW-1:0] pc4,
    input  logic [AW-1:0] rf_waddr,
    input  logic          rf_wena,
    input  logic [2:0]    rf_mux_sel,
    input  logic [2:0]    ld_type,
    input  logic [1:0]    ld_off,
    input  logic          lu_valid,
    input  logic [AW-1:0] lu_waddr,
    input  logic [DW-1:0] lu_wdata,
    output logic          lu_ready,
    input  logic [AW-1:0] lk_addr,
    output logic          lk_hit,
    output logic [DW-1:0] rf_wdata,
    output logic [AW-1:0] wb_rf_waddr,
    output logic          wb_rf_wena
);

    logic          pipe_wr;
    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    logic          q_head_valid;
    logic [AW-1:0] q_head_addr;
    logic [DW-1:0] q_head_data;
    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic [DW-1:0] ld_ext;
    logic [DW-1:0] sel_data;

    assign pipe_wr  = in_valid && rf_wena && (rf_waddr != '0);
    assign lu_ready = !q_full;
    assign q_push   = lu_valid && !q_full && (lu_waddr != '0);
    assign q_pop    = !q_empty && !pipe_wr;

    wb_pend_queue #(
        .DW     (DW),
        .AW     (AW),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (q_push),
        .push_addr  (lu_waddr),
        .push_data  (lu_wdata),
        .pop        (q_pop),
        .kill_en    (pipe_wr),
        .kill_addr  (rf_waddr),
        .lk_addr    (lk_addr),
        .lk_hit     (lk_hit),
        .full       (q_full),
        .empty      (q_empty),
        .head_valid (q_head_valid),
        .head_addr  (q_head_addr),
        .head_data  (q_head_data)
    );

    // Lane selection and sign/zero extension of the loaded word.
    always_comb begin
        byte_lane = dmem_out[8*ld_off +: 8];
        half_lane = dmem_out[16*ld_off[1] +: 16];
        case (ld_type)
            LD_LB:   ld_ext = {{(DW-8){byte_lane[7]}}, byte_lane};
            LD_LBU:  ld_ext = {{(DW-8){1'b0}}, byte_lane};
            LD_LH:   ld_ext = {{(DW-16){half_lane[15]}}, half_lane};
            LD_LHU:  ld_ext = {{(DW-16){1'b0}}, half_lane};
            default: ld_ext = dmem_out;
        endcase
    end

    // Write-data source mux.
    always_comb begin
        case (rf_mux_sel)
            SEL_PC4:  sel_data = pc4;
            SEL_DMEM: sel_data = ld_ext;
            SEL_ALU:  sel_data = alu_out;
            default:  sel_data = '0;
        endcase
    end

    // Port register: pipeline write wins; otherwise the queue head drains.
    // A killed head is consumed with the enable low and the port value held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rf_wena  <= 1'b0;
            wb_rf_waddr <= '0;
            rf_wdata    <= '0;
        end else if (pipe_wr) begin
            wb_rf_wena  <= 1'b1;
            wb_rf_waddr <= rf_waddr;
            rf_wdata    <= sel_data;
        end else if (q_pop) begin
            wb_rf_wena <= q_head_valid;
            if (q_head_valid) begin
                wb_rf_waddr <= q_head_addr;
                rf_wdata    <= q_head_data;
            end
        end else begin
            wb_rf_wena <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_wb_arb.sv
// Scoreboard bench for pipe_wb_arb: expected port writes are queued in issue
// order and a negedge monitor checks every asserted write against them.
module tb_pipe_wb_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] alu_out;
    logic [31:0] dmem_out;
    logic [31:0] pc4;
    logic [4:0]  rf_waddr;
    logic        rf_wena;
    logic [2:0]  rf_mux_sel;
    logic [2:0]  ld_type;
    logic [1:0]  ld_off;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic [4:0]  lk_addr;
    logic        lk_hit;
    logic [31:0] rf_wdata;
    logic [4:0]  wb_rf_waddr;
    logic        wb_rf_wena;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pipe_wb_arb #(
        .DW     (32),
        .AW     (5),
        .QDEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .alu_out     (alu_out),
        .dmem_out    (dmem_out),
        .pc4         (pc4),
        .rf_waddr    (rf_waddr),
        .rf_wena     (rf_wena),
        .rf_mux_sel  (rf_mux_sel),
        .ld_type     (ld_type),
        .ld_off      (ld_off),
        .lu_valid    (lu_valid),
        .lu_waddr    (lu_waddr),
        .lu_wdata    (lu_wdata),
        .lu_ready    (lu_ready),
        .lk_addr     (lk_addr),
        .lk_hit      (lk_hit),
        .rf_wdata    (rf_wdata),
        .wb_rf_waddr (wb_rf_waddr),
        .wb_rf_wena  (wb_rf_wena)
    );

    always #5 clk = ~clk;

    // Monitor: every asserted write must match the oldest expectation.
    always @(negedge clk) begin
        if (wb_rf_wena === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got r%0d=0x%08h, none expected", wb_rf_waddr, rf_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ((wb_rf_waddr !== e.a) || (rf_wdata !== e.d)) begin
                    errors++;
                    $display("FAIL port_write: got r%0d=0x%08h, expected r%0d=0x%08h",
                             wb_rf_waddr, rf_wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        rf_wena  = 1'b0;
        lu_valid = 1'b0;
    endtask

    task automatic pipe(input logic [4:0] a, input logic [31:0] d);
        in_valid   = 1'b1;
        rf_wena    = 1'b1;
        rf_waddr   = a;
        rf_mux_sel = 3'd5;
        alu_out    = d;
    endtask

    task automatic lu(input logic [4:0] a, input logic [31:0] d);
        lu_valid = 1'b1;
        lu_waddr = a;
        lu_wdata = d;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic lk(input logic [4:0] a, input logic expv, input string name);
        lk_addr = a;
        #1;
        chk(name, {31'd0, lk_hit}, {31'd0, expv});
    endtask

    task automatic drained(input string name);
        chk(name, exp_q.size(), 32'd0);
    endtask

    // Load-extension vectors: ld_type, ld_off, expected value for 0x80FF7F01.
    logic [2:0]  lv_type [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd2, 3'd4, 3'd7};
    logic [1:0]  lv_off  [8] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3, 2'd3, 2'd0};
    logic [31:0] lv_exp  [8] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
                                 32'h80FF7F01, 32'h00000080, 32'h000080FF, 32'h80FF7F01};

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; alu_out = '0; dmem_out = '0; pc4 = '0;
        rf_waddr = '0; rf_wena = 1'b0; rf_mux_sel = '0; ld_type = '0; ld_off = '0;
        lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0; lk_addr = 5'd1;

        // Reset state
        step(); step();
        chk("rst_wena",  {31'd0, wb_rf_wena}, 32'd0);
        chk("rst_waddr", {27'd0, wb_rf_waddr}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
        lk(5'd1, 1'b0, "rst_lk_hit");
        rst_n = 1'b1;
        step();

        // Load extension and source mux
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; rf_wena = 1'b1; rf_waddr = 5'(i + 1);
            rf_mux_sel = 3'd4; dmem_out = 32'h80FF7F01;
            ld_type = lv_type[i]; ld_off = lv_off[i];
            expect_wr(5'(i + 1), lv_exp[i]);
            step();
        end
        rf_mux_sel = 3'd1; pc4 = 32'h00001234; rf_waddr = 5'd10;
        expect_wr(5'd10, 32'h00001234);
        step();
        rf_mux_sel = 3'd2; alu_out = 32'hDEADBEEF; rf_waddr = 5'd11;
        expect_wr(5'd11, 32'h00000000);
        step();
        idle(); step(); step();
        drained("ld_ext_drain");

        // Arbitration: pipeline r9 x3 has priority over queued r8
        expect_wr(5'd9, 32'h1); expect_wr(5'd9, 32'h2); expect_wr(5'd9, 32'h3);
        expect_wr(5'd8, 32'hAA);
        pipe(5'd9, 32'h1); lu(5'd8, 32'hAA);
        step();
        lu_valid = 1'b0;
        lk(5'd8, 1'b1, "lk_hit_r8_queued");
        pipe(5'd9, 32'h2); step();
        pipe(5'd9, 32'h3); step();
        idle(); step();
        step();
        drained("arb_first_idle");
        lk(5'd8, 1'b0, "lk_hit_r8_drained");

        // WAW kill: queued r5=0x11 is overtaken by pipeline r5=0x22
        expect_wr(5'd6, 32'h66); expect_wr(5'd5, 32'h22);
        pipe(5'd6, 32'h66); lu(5'd5, 32'h11);
        step();
        lu_valid = 1'b0;
        lk(5'd5, 1'b1, "lk_hit_r5_queued");
        pipe(5'd5, 32'h22);
        step();
        lk(5'd5, 1'b0, "lk_hit_r5_killed");
        idle(); step(); step(); step();
        drained("waw_drain");
        chk("waw_lu_ready", {31'd0, lu_ready}, 32'd1);

        // Same-edge push to the written address is younger and survives
        expect_wr(5'd7, 32'h1); expect_wr(5'd7, 32'h77);
        pipe(5'd7, 32'h1); lu(5'd7, 32'h77);
        step();
        idle();
        lk(5'd7, 1'b1, "lk_hit_r7_younger");
        step(); step();
        drained("younger_drain");

        // Full queue, refusal while full, drain in FIFO order across wrap
        for (int i = 0; i < 5; i++) expect_wr(5'(20 + i), 32'h100 + 32'(i));
        expect_wr(5'd12, 32'hC0);
        expect_wr(5'd25, 32'h105);
        expect_wr(5'd13, 32'hC1); expect_wr(5'd14, 32'hC2); expect_wr(5'd15, 32'hC3);
        expect_wr(5'd17, 32'hD1);
        for (int i = 0; i < 4; i++) begin
            pipe(5'(20 + i), 32'h100 + 32'(i));
            lu(5'(12 + i), 32'hC0 + 32'(i));
            step();
        end
        chk("full_lu_ready", {31'd0, lu_ready}, 32'd0);
        lk(5'd15, 1'b1, "lk_hit_r15_full");
        pipe(5'd24, 32'h104); lu(5'd16, 32'hC4);
        step();
        chk("full_hold_lu_ready", {31'd0, lu_ready}, 32'd0);
        in_valid = 1'b0; rf_wena = 1'b0;
        #1;
        chk("full_pop_cycle_lu_ready", {31'd0, lu_ready}, 32'd0);
        step();
        chk("after_pop_lu_ready", {31'd0, lu_ready}, 32'd1);
        lk(5'd16, 1'b0, "lk_hit_r16_refused");
        pipe(5'd25, 32'h105); lu(5'd17, 32'hD1);
        step();
        idle();
        for (int i = 0; i < 5; i++) step();
        drained("full_drain");
        chk("drained_lu_ready", {31'd0, lu_ready}, 32'd1);

        // $0 and non-writing pipeline cycles: no port write, no queue entry
        rf_mux_sel = 3'd5;
        pipe(5'd0, 32'h999); lu(5'd0, 32'h55);
        step();
        chk("r0_lu_ready", {31'd0, lu_ready}, 32'd1);
        lk(5'd0, 1'b0, "lk_hit_r0");
        in_valid = 1'b1; rf_wena = 1'b0; rf_waddr = 5'd3; lu_valid = 1'b0;
        step();
        in_valid = 1'b0; rf_wena = 1'b1; rf_waddr = 5'd4;
        step();
        idle(); step(); step();
        drained("r0_no_write");

        // Reset mid-stream: 3 queued entries, a dropped $0 push, then reset
        for (int i = 0; i < 4; i++) expect_wr(5'(21 + i), 32'h200 + 32'(i));
        for (int i = 0; i < 3; i++) begin
            pipe(5'(21 + i), 32'h200 + 32'(i));
            lu(5'(1 + i), 32'h300 + 32'(i));
            step();
        end
        pipe(5'd24, 32'h203); lu(5'd0, 32'h3FF);
        step();
        chk("r0_push_dropped_lu_ready", {31'd0, lu_ready}, 32'd1);
        lk(5'd3, 1'b1, "lk_hit_r3_before_rst");
        idle();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_wena",  {31'd0, wb_rf_wena}, 32'd0);
        chk("midrst_waddr", {27'd0, wb_rf_waddr}, 32'd0);
        chk("midrst_lu_ready", {31'd0, lu_ready}, 32'd1);
        lk(5'd1, 1'b0, "midrst_lk_hit");
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        drained("midrst_no_queued_write");
        chk("end_lu_ready", {31'd0, lu_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_wb_arb.md
Name: pipe_wb_arb

Overview:
Parametrised registered write-back stage for the MIPS pipeline CPU. It registers the MEM/WB result, selects and load-extends the write data, and drives the single register-file write port. It also arbitrates that port against results from long-latency units (multiplier/divider/CP0) through a small pending-write queue, with WAW kill and a hazard lookup port for the ID stage.

Parameters:
DW, 32, datapath width (multiple of 16)
AW, 5, register address width
QDEPTH, 4, pending-write queue depth (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  MEM stage presents an instruction this cycle
alu_out  input  DW  ALU result
dmem_out  input  DW  raw data-memory word
pc4  input  DW  PC+4 link value
rf_waddr  input  AW  destination register
rf_wena  input  1  instruction writes regfile
rf_mux_sel  input  3  source select: 1=pc4, 4=dmem (extended), 5=alu, others=0
ld_type  input  3  0=word, 1=lb, 2=lbu, 3=lh, 4=lhu, others=word
ld_off  input  2  byte offset of load address
lu_valid  input  1  long-latency unit offers a result
lu_waddr  input  AW  its destination
lu_wdata  input  DW  its data
lu_ready  output  1  queue can accept (not full)
lk_addr  input  AW  ID-stage lookup address
lk_hit  output  1  lk_addr is nonzero and matches a valid queued entry
rf_wdata  output  DW  regfile write data
wb_rf_waddr  output  AW  regfile write address
wb_rf_wena  output  1  regfile write enable

Behaviour:
- Reset (rst_n low, async): wb_rf_wena=0, wb_rf_waddr=0, rf_wdata=0, queue empty, lu_ready=1, lk_hit=0. Reset mid-operation discards all queued entries.
- Pipeline path latency 1: values on the cycle in_valid&&rf_wena&&rf_waddr!=0 appear on the outputs after the next rising edge with wb_rf_wena=1.
- in_valid=0, rf_wena=0 or rf_waddr=0: no pipeline write; the port is free for the queue.
- Load extension when rf_mux_sel=4: byte lane = dmem_out[8*ld_off +: 8]; halfword lane = ld_off[1] ? upper half : lower half (ld_off[0] ignored); lb/lh sign-extend, lbu/lhu zero-extend to DW; word passes through.
- Queue: FIFO of {addr, data, valid}. Push when lu_valid && lu_ready && lu_waddr!=0. A write to $0 is accepted and dropped. lu_ready = !full, combinational from registered state.
- Arbitration per cycle: a pipeline write has priority. The queue head pops onto the port only in cycles with no pipeline write. Pop latency is 1 cycle, registered like the pipeline path.
- Push and pop in the same cycle are allowed. When full, a simultaneous pop does not raise lu_ready in that cycle.
- WAW kill: when a pipeline write is accepted, every valid queued entry with an equal address has its valid bit cleared in the same edge. A push in the same cycle to that address is not killed, because it is younger.
- An invalidated entry at the head is popped without asserting wb_rf_wena, which costs one cycle of port time.
- lk_hit is combinational over valid entries and excludes address 0.
- Pointer wrap uses an extra MSB on the pointers: full = MSBs differ with the rest equal; empty = pointers equal.

Decomposition:
- Shared package: load-type encodings, mux-select encodings, DW/AW defaults.
- One sub-module, wb_pend_queue, is natural. It holds the FIFO storage, pointers, per-entry valid bits, the kill compare and the lookup compare.
- Extension and mux logic stays in the top module.

Test Plan:
- Reset mid-stream: fill queue with 3 entries, pull rst_n low -> wb_rf_wena=0 immediately, lu_ready=1, no queued write ever appears.
- Load extension, dmem_out=0x80FF7F01, rf_mux_sel=4:
  - lb off=3 -> 0xFFFFFF80
  - lbu off=1 -> 0x0000007F
  - lh off=2 -> 0xFFFF80FF
  - lhu off=0 -> 0x00007F01
- Arbitration: lu pushes r8=0xAA, pipeline writes r9 for 3 consecutive cycles -> r9 writes on 3 consecutive cycles, then r8=0xAA on the first idle cycle.
- WAW kill: queue r5=0x11, pipeline writes r5=0x22 -> port shows 0x22 only, lk_hit(r5) drops to 0 after the edge, queued entry is never written.
- Full queue: push QDEPTH entries while the pipeline writes continuously -> lu_ready=0. One idle cycle -> one pop, lu_ready=1 the next cycle. Entries drain in FIFO order across pointer wrap.
- $0 handling: pipeline rf_waddr=0 and lu_waddr=0 -> wb_rf_wena never asserted, queue occupancy unchanged.
